param_dcache: RTL and testbench



---
 rtl/param_dcache.sv | 228 ++++++++++++++++++++++
 tb/tb_param_dcache.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_dcache.sv
`default_nettype none
// ============================================================================
//  Module      : param_dcache
//  Description : Write-back, write-allocate, N-way set-associative data cache
//                with true-LRU replacement and a dirty-line flush on halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_dcache #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore
);
  localparam int c_OFFW = $clog2(BLKWORDS);
  localparam int c_IDXW = $clog2(SETS);
  localparam int c_WAYB = $clog2(WAYS);
  localparam int c_TAGW = 30 - c_OFFW - c_IDXW;
  localparam int c_WCW  = (c_OFFW > 0) ? c_OFFW : 1;
  localparam int c_WYW  = (c_WAYB > 0) ? c_WAYB : 1;
  localparam int c_FCW  = c_IDXW + c_WAYB;
  localparam logic [c_WCW-1:0] c_LASTW = c_WCW'(BLKWORDS - 1);
  localparam logic [c_FCW-1:0] c_LASTF = c_FCW'(SETS * WAYS - 1);
  localparam logic [c_WYW-1:0] c_OLD   = c_WYW'(WAYS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FETCH, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  logic [c_WCW-1:0]  r_wcnt;
  logic [c_FCW-1:0]  r_fcnt;
  logic [c_WYW-1:0]  r_vway;
  logic [c_IDXW-1:0] r_ridx;
  logic [c_TAGW-1:0] r_rtag;
  logic              r_flushed;

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [c_WYW-1:0]  r_age   [SETS][WAYS];
  logic [c_TAGW-1:0] r_tag   [SETS][WAYS];
  logic [31:0]       r_data  [SETS][WAYS][BLKWORDS];

  logic [c_TAGW-1:0] w_tag;
  logic [c_IDXW-1:0] w_idx;
  logic [c_WCW-1:0]  w_woff;
  logic              w_req, w_hit, w_inv, w_vdirty, w_fdirty;
  logic [c_WYW-1:0]  w_hway, w_invway, w_lruway, w_vway, w_fway;
  logic [c_IDXW-1:0] w_fidx;
  logic              w_unused;

  // Word-aligned memory address of one word of a line
  function automatic logic [31:0] f_addr(input logic [c_TAGW-1:0] t,
                                         input logic [c_IDXW-1:0] i,
                                         input logic [c_WCW-1:0]  w);
    return (32'(t) << (2 + c_OFFW + c_IDXW)) | (32'(i) << (2 + c_OFFW)) | (32'(w) << 2);
  endfunction

  assign w_tag    = c_TAGW'(dmemaddr >> (2 + c_OFFW + c_IDXW));
  assign w_idx    = c_IDXW'(dmemaddr >> (2 + c_OFFW));
  assign w_woff   = c_WCW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));
  assign w_req    = (dmemREN | dmemWEN) & ~halt;
  assign w_unused = ^dmemaddr[1:0];

  // Flush scan walks entries set-major, way-minor
  assign w_fidx   = c_IDXW'(r_fcnt >> c_WAYB);
  assign w_fway   = c_WYW'(r_fcnt & c_FCW'(WAYS - 1));
  assign w_fdirty = r_valid[w_fidx][w_fway] & r_dirty[w_fidx][w_fway];

  // Tag lookup and victim choice: lowest invalid way first, else the oldest way
  always_comb begin
    w_hit    = 1'b0;
    w_hway   = '0;
    w_inv    = 1'b0;
    w_invway = '0;
    w_lruway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = c_WYW'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv    = 1'b1;
        w_invway = c_WYW'(w);
      end
      if (r_age[w_idx][w] == c_OLD) w_lruway = c_WYW'(w);
    end
    w_vway   = w_inv ? w_invway : w_lruway;
    w_vdirty = r_valid[w_idx][w_vway] & r_dirty[w_idx][w_vway];
  end

  assign dhit     = (r_state == S_IDLE) & w_req & w_hit;
  assign dmemload = dhit ? r_data[w_idx][w_hway][w_woff] : 32'd0;
  assign flushed  = r_flushed;

  // Memory-side request decoded from the registered state and counters
  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'd0;
    dstore = 32'd0;
    case (r_state)
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = f_addr(r_tag[r_ridx][r_vway], r_ridx, r_wcnt);
        dstore = r_data[r_ridx][r_vway][r_wcnt];
      end
      S_FETCH: begin
        dREN  = 1'b1;
        daddr = f_addr(r_rtag, r_ridx, r_wcnt);
      end
      S_FLUSH: begin
        if (w_fdirty) begin
          dWEN   = 1'b1;
          daddr  = f_addr(r_tag[w_fidx][w_fway], w_fidx, r_wcnt);
          dstore = r_data[w_fidx][w_fway][r_wcnt];
        end
      end
      default: ;
    endcase
  end

  // Controller: hit/miss handling, write-back, fetch, flush and line state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_fcnt    <= '0;
      r_vway    <= '0;
      r_ridx    <= '0;
      r_rtag    <= '0;
      r_flushed <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= c_WYW'(w);
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (halt) begin
            r_state <= S_FLUSH;
            r_fcnt  <= '0;
            r_wcnt  <= '0;
          end else if (w_req) begin
            if (w_hit) begin
              for (int w = 0; w < WAYS; w++) begin
                if (w_hway == c_WYW'(w)) r_age[w_idx][w] <= '0;
                else if (r_age[w_idx][w] < r_age[w_idx][w_hway])
                  r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
              end
              if (dmemWEN) r_dirty[w_idx][w_hway] <= 1'b1;
            end else begin
              r_vway  <= w_vway;
              r_ridx  <= w_idx;
              r_rtag  <= w_tag;
              r_wcnt  <= '0;
              r_state <= w_vdirty ? S_WB : S_FETCH;
            end
          end
        end
        S_WB: begin
          if (!dwait) begin
            if (r_wcnt == c_LASTW) begin
              r_wcnt  <= '0;
              r_state <= S_FETCH;
            end else r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (!dwait) begin
            if (r_wcnt == c_LASTW) begin
              r_wcnt                 <= '0;
              r_valid[r_ridx][r_vway] <= 1'b1;
              r_dirty[r_ridx][r_vway] <= 1'b0;
              r_state                <= S_IDLE;
            end else r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_fdirty) begin
            if (!dwait) begin
              if (r_wcnt == c_LASTW) begin
                r_wcnt                  <= '0;
                r_dirty[w_fidx][w_fway] <= 1'b0;
                if (r_fcnt == c_LASTF) begin
                  r_state   <= S_DONE;
                  r_flushed <= 1'b1;
                end else r_fcnt <= r_fcnt + 1'b1;
              end else r_wcnt <= r_wcnt + 1'b1;
            end
          end else if (r_fcnt == c_LASTF) begin
            r_state   <= S_DONE;
            r_flushed <= 1'b1;
          end else r_fcnt <= r_fcnt + 1'b1;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line payload: write hits and fetched words; tag lands with the last word
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) r_data[w_idx][w_hway][w_woff] <= dmemstore;
    if ((r_state == S_FETCH) && !dwait) begin
      r_data[r_ridx][r_vway][r_wcnt] <= dload;
      if (r_wcnt == c_LASTW) r_tag[r_ridx][r_vway] <= r_rtag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_dcache.sv
module tb_param_dcache;
  logic        CLK = 1'b0, nRST = 1'b1, halt = 1'b0, ren = 1'b0, wen = 1'b0, dwait = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, dload = 32'd0;
  int          sel = 0;

  always #5 CLK = ~CLK;

  logic        ren0, wen0, h0, ren1, wen1, h1;
  logic        dhit0, dhit1, fl0, fl1, dren0, dren1, dwen0, dwen1;
  logic [31:0] ld0, ld1, da0, da1, ds0, ds1;
  logic        dhit_m, fl_m, dren_m, dwen_m;
  logic [31:0] ld_m, da_m, ds_m;

  assign ren0 = ren & (sel == 0);
  assign wen0 = wen & (sel == 0);
  assign h0   = halt & (sel == 0);
  assign ren1 = ren & (sel == 1);
  assign wen1 = wen & (sel == 1);
  assign h1   = halt & (sel == 1);
  assign dhit_m = (sel == 1) ? dhit1 : dhit0;
  assign fl_m   = (sel == 1) ? fl1 : fl0;
  assign dren_m = (sel == 1) ? dren1 : dren0;
  assign dwen_m = (sel == 1) ? dwen1 : dwen0;
  assign ld_m   = (sel == 1) ? ld1 : ld0;
  assign da_m   = (sel == 1) ? da1 : da0;
  assign ds_m   = (sel == 1) ? ds1 : ds0;

  param_dcache #(.SETS(8), .WAYS(2), .BLKWORDS(2)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .halt(h0), .dmemREN(ren0), .dmemWEN(wen0),
    .dmemaddr(addr), .dmemstore(wdata), .dhit(dhit0), .dmemload(ld0), .flushed(fl0),
    .dwait(dwait), .dload(dload), .dREN(dren0), .dWEN(dwen0), .daddr(da0), .dstore(ds0));

  param_dcache #(.SETS(8), .WAYS(4), .BLKWORDS(4)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .halt(h1), .dmemREN(ren1), .dmemWEN(wen1),
    .dmemaddr(addr), .dmemstore(wdata), .dhit(dhit1), .dmemload(ld1), .flushed(fl1),
    .dwait(dwait), .dload(dload), .dREN(dren1), .dWEN(dwen1), .daddr(da1), .dstore(ds1));

  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct { bit wr; logic [31:0] a; logic [31:0] d; } xfer_t;
  xfer_t       log_q[$], exp_q[$];
  logic [31:0] bmem[logic [31:0]];
  logic [31:0] mmem[logic [31:0]];

  // Memory responder: stalls each transfer, then serves/stores one word
  int stall_mode = 0, left = 0;
  bit busy = 0;
  always @(negedge CLK) begin
    if (!nRST || !(dren_m || dwen_m)) begin
      busy  = 0;
      dwait = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1;
        left = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
      end
      if (left > 0) begin
        dwait = 1'b1;
        left--;
      end else begin
        dwait = 1'b0;
        busy  = 0;
        if (dren_m) begin
          dload = bmem.exists(da_m) ? bmem[da_m] : 32'hECE436C0 + da_m;
          log_q.push_back('{1'b0, da_m, dload});
        end else begin
          bmem[da_m] = ds_m;
          log_q.push_back('{1'b1, da_m, ds_m});
        end
      end
    end
  end

  // Per-cycle compare: exclusivity, no hit under halt, quiet when flushed, stall stability
  logic [31:0] p_a, p_s;
  logic        p_r, p_w;
  bit          p_stall = 0;
  always @(negedge CLK) begin
    #2;
    if (!nRST) p_stall = 0;
    else begin
      check("rd_wr_exclusive", {31'd0, dren_m & dwen_m}, 32'd0);
      if (halt) check("dhit_under_halt", {31'd0, dhit_m}, 32'd0);
      if (fl_m) check("flushed_quiet", {30'd0, dren_m, dwen_m}, 32'd0);
      if (p_stall) begin
        check("stall_daddr", da_m, p_a);
        check("stall_rw", {30'd0, dren_m, dwen_m}, {30'd0, p_r, p_w});
        if (p_w) check("stall_dstore", ds_m, p_s);
      end
      p_stall = dwait && (dren_m || dwen_m);
      p_a = da_m; p_s = ds_m; p_r = dren_m; p_w = dwen_m;
    end
  end

  // Behavioural cache model: per-line records, LRU by last-use timestamp
  int          ms = 8, mw = 2, mb = 2, tick = 0;
  bit          mv[8][4], md[8][4];
  logic [31:0] mt[8][4];
  logic [31:0] mdat[8][4][4];
  int          mst[8][4];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'hECE436C0 + a;
  endfunction

  task automatic model_reset(input int s, input int w, input int b);
    ms = s; mw = w; mb = b; tick = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) begin
        mv[i][j] = 0; md[i][j] = 0; mst[i][j] = 0;
      end
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                              output int lat, output logic [31:0] rd);
    int wo, st, way;
    logic [31:0] tg, wa, va;
    bit dirty;
    wa = a >> 2;
    wo = int'(wa % mb);
    st = int'((wa / mb) % ms);
    tg = wa / mb / ms;
    exp_q.delete();
    way = -1;
    lat = 0;
    for (int w = 0; w < mw; w++) if (mv[st][w] && mt[st][w] == tg) way = w;
    if (way < 0) begin
      for (int w = mw - 1; w >= 0; w--) if (!mv[st][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < mw; w++) if (mst[st][w] < mst[st][way]) way = w;
      end
      dirty = mv[st][way] && md[st][way];
      if (dirty)
        for (int i = 0; i < mb; i++) begin
          va = ((mt[st][way] * ms + st) * mb + i) << 2;
          mmem[va] = mdat[st][way][i];
          exp_q.push_back('{1'b1, va, mdat[st][way][i]});
        end
      for (int i = 0; i < mb; i++) begin
        va = ((tg * ms + st) * mb + i) << 2;
        mdat[st][way][i] = mrd(va);
        exp_q.push_back('{1'b0, va, 32'd0});
      end
      mv[st][way] = 1; md[st][way] = 0; mt[st][way] = tg;
      lat = (dirty ? 2 : 1) * mb + 1;
    end
    tick++;
    mst[st][way] = tick;
    if (wr) begin
      mdat[st][way][wo] = wd;
      md[st][way] = 1;
    end
    rd = mdat[st][way][wo];
  endtask

  task automatic model_flush();
    logic [31:0] va;
    exp_q.delete();
    for (int s = 0; s < ms; s++)
      for (int w = 0; w < mw; w++)
        if (mv[s][w] && md[s][w]) begin
          for (int i = 0; i < mb; i++) begin
            va = ((mt[s][w] * ms + s) * mb + i) << 2;
            mmem[va] = mdat[s][w][i];
            exp_q.push_back('{1'b1, va, mdat[s][w][i]});
          end
          md[s][w] = 0;
        end
  endtask

  task automatic compare_xfers(input string tag);
    int n;
    check({tag, "_xfer_count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_xfer%0d_addr", tag, i), log_q[i].a, exp_q[i].a);
      check($sformatf("%s_xfer%0d_rw", tag, i), {31'd0, log_q[i].wr}, {31'd0, exp_q[i].wr});
      if (exp_q[i].wr) check($sformatf("%s_xfer%0d_data", tag, i), log_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic access(input logic [31:0] a, input bit w, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    int elat, cyc;
    logic [31:0] erd;
    bit got;
    model_access(a, w, wd, elat, erd);
    @(negedge CLK);
    log_q.delete();
    addr = a; wdata = wd; ren = !w; wen = w;
    cyc = 0; got = 0; rd = 32'd0;
    while (!got && cyc < 400) begin
      #1;
      if (dhit_m) got = 1;
      else begin
        @(negedge CLK);
        cyc++;
      end
    end
    check($sformatf("dhit_reached@%h", a), {31'd0, got}, 32'd1);
    if (got) begin
      rd = ld_m;
      @(posedge CLK);
      #1;
    end
    ren = 0; wen = 0;
    lat = cyc;
    if (!w) check($sformatf("load@%h", a), rd, erd);
    if (stall_mode == 0) check($sformatf("latency@%h", a), lat, elat);
    compare_xfers($sformatf("acc@%h", a));
  endtask

  task automatic do_reset(input int s, input int w, input int b);
    ren = 0; wen = 0; halt = 0;
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_dhit", {31'd0, dhit_m}, 32'd0);
    check("rst_flushed", {31'd0, fl_m}, 32'd0);
    check("rst_dren_dwen", {30'd0, dren_m, dwen_m}, 32'd0);
    check("rst_daddr", da_m, 32'd0);
    check("rst_dstore", ds_m, 32'd0);
    check("rst_dmemload", ld_m, 32'd0);
    model_reset(s, w, b);
    nRST = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc;
    logic [31:0] rd;

    // ---- default geometry: 8 sets, 2 ways, 2 words ----
    sel = 0; stall_mode = 0;
    do_reset(8, 2, 2);
    access(32'h40, 0, 0, lat, rd);
    check("lit_first_load", rd, 32'hECE43700);
    check("lit_first_latency", lat, 32'd3);
    check("lit_first_fetch0", log_q[0].a, 32'h40);
    check("lit_first_fetch1", log_q[1].a, 32'h44);
    access(32'h44, 0, 0, lat, rd);
    check("lit_rehit_load", rd, 32'hECE43704);
    check("lit_rehit_latency", lat, 32'd0);

    do_reset(8, 2, 2);
    access(32'h40, 0, 0, lat, rd);
    access(32'h80, 0, 0, lat, rd);
    access(32'h40, 0, 0, lat, rd);
    access(32'hC0, 0, 0, lat, rd);
    access(32'h40, 0, 0, lat, rd);
    check("lit_lru_keep_latency", lat, 32'd0);
    access(32'h80, 0, 0, lat, rd);
    check("lit_lru_evicted_latency", lat, 32'd3);

    do_reset(8, 2, 2);
    access(32'h80, 1, 32'h0CADF00D, lat, rd);
    access(32'h40, 0, 0, lat, rd);
    access(32'hC0, 0, 0, lat, rd);
    check("lit_dirty_latency", lat, 32'd5);
    check("lit_wb0_addr", log_q[0].a, 32'h80);
    check("lit_wb0_data", log_q[0].d, 32'h0CADF00D);
    check("lit_wb1_addr", log_q[1].a, 32'h84);
    check("lit_wb1_data", log_q[1].d, 32'hECE43744);

    // ---- held dwait on every transfer ----
    stall_mode = 3;
    access(32'h100, 1, 32'h11112222, lat, rd);
    access(32'h140, 1, 32'h33334444, lat, rd);
    access(32'h180, 0, 0, lat, rd);
    access(32'h104, 0, 0, lat, rd);
    stall_mode = 0;

    // ---- halt flush with dirty lines in set 0 and set 7 ----
    do_reset(8, 2, 2);
    access(32'h00, 1, 32'hA5A5A5A5, lat, rd);
    access(32'h38, 1, 32'h5A5A5A5A, lat, rd);
    model_flush();
    @(negedge CLK);
    log_q.delete();
    halt = 1; ren = 1; addr = 32'h00;
    cyc = 0;
    while (!fl_m && cyc < 200) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("flush_reached", {31'd0, fl_m}, 32'd1);
    compare_xfers("flush");
    check("lit_flush_count", log_q.size(), 32'd4);
    check("lit_flush_first", log_q[0].a, 32'h00);
    check("lit_flush_first_data", log_q[0].d, 32'hA5A5A5A5);
    check("lit_flush_third", log_q[2].a, 32'h38);
    repeat (5) @(negedge CLK);
    #3;
    check("flushed_held", {31'd0, fl_m}, 32'd1);
    check("flush_no_dhit", {31'd0, dhit_m}, 32'd0);
    ren = 0; halt = 0;

    // ---- random traffic, default geometry ----
    do_reset(8, 2, 2);
    stall_mode = -1;
    repeat (150) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 63)) << 2;
      access(ra, bit'($urandom_range(0, 1)), $urandom, lat, rd);
    end
    stall_mode = 0;

    // ---- 4-way, 4-word geometry ----
    sel = 1;
    do_reset(8, 4, 4);
    for (int t = 1; t <= 5; t++) access(32'(t) << 7, 0, 0, lat, rd);
    access(32'h80, 0, 0, lat, rd);
    check("lit_w4_first_evicted", lat, 32'd5);
    access(32'h180, 0, 0, lat, rd);
    check("lit_w4_kept_hit", lat, 32'd0);
    access(32'h100, 0, 0, lat, rd);
    check("lit_w4_second_evicted", lat, 32'd5);

    // reset in the middle of a fetch
    @(negedge CLK);
    log_q.delete();
    addr = 32'h400; ren = 1;
    cyc = 0;
    while (log_q.size() < 2 && cyc < 50) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("midfetch_reached", {31'd0, log_q.size() >= 2}, 32'd1);
    nRST = 1'b0;
    #1;
    check("abort_dren_dwen", {30'd0, dren_m, dwen_m}, 32'd0);
    check("abort_daddr", da_m, 32'd0);
    check("abort_dstore", ds_m, 32'd0);
    check("abort_dhit", {31'd0, dhit_m}, 32'd0);
    check("abort_dmemload", ld_m, 32'd0);
    ren = 0;
    repeat (2) @(negedge CLK);
    model_reset(8, 4, 4);
    nRST = 1'b1;
    access(32'h400, 0, 0, lat, rd);
    check("lit_after_abort_miss", lat, 32'd5);
    access(32'h80, 0, 0, lat, rd);
    check("lit_after_abort_old_miss", lat, 32'd5);

    stall_mode = -1;
    repeat (100) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 511)) << 2;
      access(ra, bit'($urandom_range(0, 1)), $urandom, lat, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
